// File: rtl/secure_frv_masked_pkg.sv
`default_nettype none
// ============================================================================
// Module      : secure_frv_masked_pkg
// Description : Shared sizing and slicing helpers for the masked datapath.
//               Share s of a BIT_WIDTH-wide operand lives at [s*BW +: BW];
//               random pair k lives at [k*BW +: BW].
// Revision    : 1.0 - initial release
// ============================================================================
package secure_frv_masked_pkg;

  // Number of Boolean shares for masking order d.
  function automatic int n_shares(input int d);
    return d + 1;
  endfunction

  // Random bits needed per operand bit: one per unordered share pair.
  function automatic int n_rand(input int d);
    return (d * (d + 1)) / 2;
  endfunction

  // Width of the randomness port; never zero, so order 0 still has a legal port.
  function automatic int rand_width(input int d, input int bw);
    return (d == 0) ? 1 : n_rand(d) * bw;
  endfunction

  // Index of the random word shared by cross terms (i,j) and (j,i).
  function automatic int pair_idx(input int i, input int j, input int n);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * n - (lo * (lo + 1)) / 2 + (hi - lo - 1);
  endfunction

  function automatic int share_lsb(input int s, input int bw);
    return s * bw;
  endfunction

  function automatic int rand_lsb(input int k, input int bw);
    return k * bw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/secure_frv_dom_term.sv
`default_nettype none
// ============================================================================
// Module      : secure_frv_dom_term
// Description : One DOM-indep cross-domain term register:
//               term <= (a_share & b_share) ^ mask on load, 0 on zeroise.
//               The register is the glitch barrier between share domains.
// Ports       : g_clk, g_resetn (async, active low), i_load, i_zeroise,
//               i_a_share, i_b_share, i_mask [BIT_WIDTH], o_term [BIT_WIDTH]
// Revision    : 1.0 - initial release
// ============================================================================
module secure_frv_dom_term #(
  parameter int BIT_WIDTH = 32
) (
  input  logic                 g_clk,
  input  logic                 g_resetn,
  input  logic                 i_load,
  input  logic                 i_zeroise,
  input  logic [BIT_WIDTH-1:0] i_a_share,
  input  logic [BIT_WIDTH-1:0] i_b_share,
  input  logic [BIT_WIDTH-1:0] i_mask,
  output logic [BIT_WIDTH-1:0] o_term
);

  logic [BIT_WIDTH-1:0] r_term;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_term <= '0;
    end else if (i_load) begin
      r_term <= (i_a_share & i_b_share) ^ i_mask;
    end else if (i_zeroise) begin
      r_term <= '0;
    end
  end

  assign o_term = r_term;

endmodule
`default_nettype wire

// File: rtl/secure_frv_masked_and_pipe.sv
`default_nettype none
// ============================================================================
// Module      : secure_frv_masked_and_pipe
// Description : Order-D masked AND (DOM-indep), N=D+1 shares, two-stage
//               valid/ready pipeline with backpressure and clock-enable stall.
//               Stage 1: N*N term registers. Stage 2: per-share XOR compression.
// Ports       : g_clk, g_resetn (async, active low), clk_en,
//               a_i/b_i [N*BW] shares, rnd_i [L*BW or 1], valid_i, ready_o,
//               q_o [N*BW] result shares, valid_o, ready_i
// Config      : SECURE_FRV_MASKED_AND_ZEROISE_EN - when defined, stage-1 and
//               output data registers clear as their stage empties.
// Revision    : 1.0 - initial release
// ============================================================================
module secure_frv_masked_and_pipe
  import secure_frv_masked_pkg::*;
#(
  parameter  int D         = 1,
  parameter  int BIT_WIDTH = 32,
  localparam int N_SHARES  = n_shares(D),
  localparam int N_RAND    = n_rand(D),
  localparam int RND_W     = rand_width(D, BIT_WIDTH)
) (
  input  logic                          g_clk,
  input  logic                          g_resetn,
  input  logic                          clk_en,
  input  logic [N_SHARES*BIT_WIDTH-1:0] a_i,
  input  logic [N_SHARES*BIT_WIDTH-1:0] b_i,
  input  logic [RND_W-1:0]              rnd_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic [N_SHARES*BIT_WIDTH-1:0] q_o,
  output logic                          valid_o,
  input  logic                          ready_i
);

  logic                                   r_v1;
  logic                                   r_v2;
  logic [N_SHARES*BIT_WIDTH-1:0]          r_q;
  logic [N_SHARES*N_SHARES*BIT_WIDTH-1:0] w_term;
  logic [N_SHARES*BIT_WIDTH-1:0]          w_q_next;
  logic                                   w_accept;
  logic                                   w_advance;
  logic                                   w_complete;
  logic                                   w_zero_s1;
  logic                                   w_zero_s2;

  // Stage 1 may take a new operand when it is empty or when its content moves on.
  assign ready_o    = !r_v1 || !r_v2 || ready_i;
  assign w_accept   = valid_i && ready_o && clk_en;
  assign w_advance  = r_v1 && (!r_v2 || ready_i) && clk_en;
  assign w_complete = r_v2 && ready_i && clk_en;

`ifdef SECURE_FRV_MASKED_AND_ZEROISE_EN
  // Clear data exactly on the cycle a stage drains without being refilled.
  assign w_zero_s1 = w_advance && !w_accept;
  assign w_zero_s2 = w_complete && !w_advance;
`else
  assign w_zero_s1 = 1'b0;
  assign w_zero_s2 = 1'b0;
`endif

  // Stage-1 term array: t[i][j] at flat index (i*N + j).
  for (genvar gi = 0; gi < N_SHARES; gi++) begin : g_row
    for (genvar gj = 0; gj < N_SHARES; gj++) begin : g_col
      logic [BIT_WIDTH-1:0] w_mask;

      if (gi == gj) begin : g_diag
        assign w_mask = '0;
      end else begin : g_cross
        // (i,j) and (j,i) consume the same random word so it cancels in the XOR of all shares.
        localparam int c_k = pair_idx(gi, gj, N_SHARES);
        assign w_mask = rnd_i[rand_lsb(c_k, BIT_WIDTH) +: BIT_WIDTH];
      end

      secure_frv_dom_term #(
        .BIT_WIDTH (BIT_WIDTH)
      ) u_term (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .i_load    (w_accept),
        .i_zeroise (w_zero_s1),
        .i_a_share (a_i[share_lsb(gi, BIT_WIDTH) +: BIT_WIDTH]),
        .i_b_share (b_i[share_lsb(gj, BIT_WIDTH) +: BIT_WIDTH]),
        .i_mask    (w_mask),
        .o_term    (w_term[(gi*N_SHARES + gj)*BIT_WIDTH +: BIT_WIDTH])
      );
    end
  end

  if (N_RAND == 0) begin : g_no_rand
    // Order 0 has no cross terms; the one-bit randomness port is ignored.
    logic w_unused_rnd;
    assign w_unused_rnd = ^rnd_i;
  end

  // Stage-2 compression: only registered terms meet here, one output share per row.
  always_comb begin
    w_q_next = '0;
    for (int s = 0; s < N_SHARES; s++) begin
      for (int j = 0; j < N_SHARES; j++) begin
        w_q_next[s*BIT_WIDTH +: BIT_WIDTH] = w_q_next[s*BIT_WIDTH +: BIT_WIDTH]
                                           ^ w_term[(s*N_SHARES + j)*BIT_WIDTH +: BIT_WIDTH];
      end
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else if (clk_en) begin
      if (w_accept) begin
        r_v1 <= 1'b1;
      end else if (w_advance) begin
        r_v1 <= 1'b0;
      end
      if (w_advance) begin
        r_v2 <= 1'b1;
      end else if (w_complete) begin
        r_v2 <= 1'b0;
      end
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_q <= '0;
    end else if (w_advance) begin
      r_q <= w_q_next;
    end else if (w_zero_s2) begin
      r_q <= '0;
    end
  end

  assign q_o     = r_q;
  assign valid_o = r_v2;

endmodule
`default_nettype wire

// File: tb/tb_secure_frv_masked_and_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_secure_frv_masked_and_pipe
// Description : Self-checking bench. dut1: D=1, BIT_WIDTH=8 (vector table and
//               directed sequences). dut2: D=2, BIT_WIDTH=4 (random traffic
//               with clk_en/ready_i toggling against an in-order queue model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_secure_frv_masked_and_pipe;

  logic clk;
  logic rst_n;

  // dut1 signals
  logic        d1_clk_en, d1_valid_i, d1_ready_o, d1_valid_o, d1_ready_i;
  logic [15:0] d1_a, d1_b, d1_q;
  logic [7:0]  d1_rnd;

  // dut2 signals
  logic        d2_clk_en, d2_valid_i, d2_ready_o, d2_valid_o, d2_ready_i;
  logic [11:0] d2_a, d2_b, d2_q, d2_rnd;

  int tests = 0;
  int fails = 0;

  logic [7:0]  q1_exp [$];
  logic [3:0]  q2_exp [$];
  int          d1_done = 0;
  logic        d1_hold = 1'b0;
  logic [15:0] d1_prev_q = '0;

  secure_frv_masked_and_pipe #(.D(1), .BIT_WIDTH(8)) dut1 (
    .g_clk    (clk),
    .g_resetn (rst_n),
    .clk_en   (d1_clk_en),
    .a_i      (d1_a),
    .b_i      (d1_b),
    .rnd_i    (d1_rnd),
    .valid_i  (d1_valid_i),
    .ready_o  (d1_ready_o),
    .q_o      (d1_q),
    .valid_o  (d1_valid_o),
    .ready_i  (d1_ready_i)
  );

  secure_frv_masked_and_pipe #(.D(2), .BIT_WIDTH(4)) dut2 (
    .g_clk    (clk),
    .g_resetn (rst_n),
    .clk_en   (d2_clk_en),
    .a_i      (d2_a),
    .b_i      (d2_b),
    .rnd_i    (d2_rnd),
    .valid_i  (d2_valid_i),
    .ready_o  (d2_ready_o),
    .q_o      (d2_q),
    .valid_o  (d2_valid_o),
    .ready_i  (d2_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One dut1 cycle: drive at negedge, observe just after, score against the queue model.
  task automatic d1_cycle(input logic v, input logic [15:0] a, input logic [15:0] b,
                          input logic [7:0] r, input logic rdy, output logic acc);
    @(negedge clk);
    d1_valid_i = v; d1_a = a; d1_b = b; d1_rnd = r; d1_ready_i = rdy; d1_clk_en = 1'b1;
    #1;
    check("d1_ready", d1_ready_o, (q1_exp.size() < 2) || rdy);
    if (d1_hold) begin
      check("d1_hold_valid", d1_valid_o, 1);
      check("d1_hold_q", d1_q, d1_prev_q);
    end
    if (d1_valid_o && rdy) begin
      if (q1_exp.size() == 0) check("d1_unexpected_result", 1, 0);
      else check("d1_result", d1_q[7:0] ^ d1_q[15:8], q1_exp.pop_front());
      d1_done++;
    end
    acc = v && d1_ready_o;
    if (acc) q1_exp.push_back((a[7:0] ^ a[15:8]) & (b[7:0] ^ b[15:8]));
    d1_hold   = d1_valid_o && !rdy;
    d1_prev_q = d1_q;
  endtask

  typedef struct packed {
    logic [7:0] a0, a1, b0, b1, r, exp;
  } vec_t;

  vec_t vec [6];

  initial begin
    logic        acc;
    int          done0;
    int          n;
    logic [15:0] sh_exp;
    logic [7:0]  xa, xb;

    vec[0] = '{8'hA5, 8'h00, 8'h3C, 8'hFF, 8'h5A, 8'h81};
    vec[1] = '{8'hFF, 8'h0F, 8'hF0, 8'h00, 8'h33, 8'hF0};
    vec[2] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h26};
    vec[3] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    vec[4] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'hA5, 8'hFF};
    vec[5] = '{8'h80, 8'h01, 8'h81, 8'h00, 8'h7E, 8'h81};

    rst_n = 1'b0;
    d1_clk_en = 1'b1; d1_valid_i = 1'b0; d1_ready_i = 1'b1; d1_a = '0; d1_b = '0; d1_rnd = '0;
    d2_clk_en = 1'b1; d2_valid_i = 1'b0; d2_ready_i = 1'b1; d2_a = '0; d2_b = '0; d2_rnd = '0;
    #12;
    check("reset_valid1", d1_valid_o, 0);
    check("reset_q1", d1_q, 0);
    check("reset_valid2", d2_valid_o, 0);
    check("reset_q2", d2_q, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table, back-to-back with ready_i=1: 2-cycle latency, ready_o always high.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i < 6) begin
        d1_valid_i = 1'b1;
        d1_a = {vec[i].a1, vec[i].a0};
        d1_b = {vec[i].b1, vec[i].b0};
        d1_rnd = vec[i].r;
      end else begin
        d1_valid_i = 1'b0;
      end
      d1_ready_i = 1'b1;
      #1;
      check("tbl_ready", d1_ready_o, 1);
      if (i >= 2) begin
        check("tbl_valid", d1_valid_o, 1);
        check("tbl_result", d1_q[7:0] ^ d1_q[15:8], vec[i-2].exp);
      end else begin
        check("tbl_latency", d1_valid_o, 0);
      end
    end
    @(negedge clk);
    #1;
    check("tbl_drained", d1_valid_o, 0);

    // Backpressure: stall from the 2nd result, 3rd accepted, 4th held off.
    done0 = d1_done;
    for (int k = 0; k < 3; k++) begin
      d1_cycle(1'b1, 16'(32'h1357 * (k + 1)), 16'(32'h2468 * (k + 3)), 8'(k * 37 + 5), 1'b1, acc);
      check("bp_accept", acc, 1);
    end
    for (int k = 0; k < 3; k++) begin
      d1_cycle(1'b1, 16'hC3A5, 16'h5AF0, 8'h99, 1'b0, acc);
      check("bp_stall", acc, 0);
    end
    n = 0;
    do begin
      d1_cycle(1'b1, 16'hC3A5, 16'h5AF0, 8'h99, 1'b1, acc);
      n++;
    end while (!acc && n < 5);
    check("bp_4th_accepted", acc, 1);
    n = 0;
    while (q1_exp.size() != 0 && n < 10) begin
      d1_cycle(1'b0, '0, '0, '0, 1'b1, acc);
      n++;
    end
    check("bp_count", 32'(d1_done - done0), 4);

    // Reset with both stages full drops everything.
    d1_cycle(1'b1, 16'hFFFF, 16'hFF00, 8'h11, 1'b0, acc);
    d1_cycle(1'b1, 16'h0FF0, 16'hF00F, 8'h22, 1'b0, acc);
    @(negedge clk);
    d1_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", d1_valid_o, 0);
    check("rst_mid_q", d1_q, 0);
    q1_exp.delete();
    d1_hold = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    done0 = d1_done;
    d1_cycle(1'b0, '0, '0, '0, 1'b1, acc);
    d1_cycle(1'b0, '0, '0, '0, 1'b1, acc);
    d1_cycle(1'b1, 16'h6699, 16'h0F3C, 8'h42, 1'b1, acc);
    n = 0;
    while (q1_exp.size() != 0 && n < 6) begin
      d1_cycle(1'b0, '0, '0, '0, 1'b1, acc);
      n++;
    end
    check("rst_post_count", 32'(d1_done - done0), 1);

    // Single op then idle: exact output shares, then zeroised or retained after drain.
    sh_exp[7:0]  = (8'hA5 & 8'h3C) ^ (8'hA5 & 8'hFF) ^ 8'h5A;
    sh_exp[15:8] = (8'h00 & 8'h3C) ^ (8'h00 & 8'hFF) ^ 8'h5A;
    d1_cycle(1'b1, 16'h00A5, 16'hFF3C, 8'h5A, 1'b1, acc);
    d1_cycle(1'b0, '0, '0, '0, 1'b1, acc);
    d1_cycle(1'b0, '0, '0, '0, 1'b1, acc);
    check("single_valid", d1_valid_o, 1);
    check("single_shares", d1_q, sh_exp);
    d1_cycle(1'b0, '0, '0, '0, 1'b1, acc);
    check("idle_valid", d1_valid_o, 0);
`ifdef SECURE_FRV_MASKED_AND_ZEROISE_EN
    check("idle_q_zeroised", d1_q, 0);
`else
    check("idle_q_retained", d1_q, sh_exp);
`endif

    // Order 2, random traffic with clk_en and ready_i toggling.
    begin
      int          done2;
      int          cyc;
      logic        en, v, rdy;
      logic        hold, frz, pv;
      logic [11:0] pq;
      hold = 1'b0; frz = 1'b0; pv = 1'b0; pq = '0;
      done2 = 0; cyc = 0;
      while (done2 < 1000 && cyc < 20000) begin
        @(negedge clk);
        en  = ($urandom_range(0, 3) != 0);
        v   = ($urandom_range(0, 3) != 0);
        rdy = ($urandom_range(0, 3) != 0);
        d2_clk_en = en; d2_valid_i = v; d2_ready_i = rdy;
        d2_a = 12'($urandom); d2_b = 12'($urandom); d2_rnd = 12'($urandom);
        #1;
        check("d2_ready", d2_ready_o, (q2_exp.size() < 2) || rdy);
        if (frz) check("d2_frozen_valid", d2_valid_o, pv);
        if (hold) begin
          check("d2_hold_valid", d2_valid_o, 1);
          check("d2_hold_q", d2_q, pq);
        end
        if (d2_valid_o && rdy && en) begin
          if (q2_exp.size() == 0) check("d2_unexpected_result", 1, 0);
          else check("d2_result", d2_q[3:0] ^ d2_q[7:4] ^ d2_q[11:8], q2_exp.pop_front());
          done2++;
        end
        if (v && d2_ready_o && en) begin
          xa = 8'(d2_a[3:0] ^ d2_a[7:4] ^ d2_a[11:8]);
          xb = 8'(d2_b[3:0] ^ d2_b[7:4] ^ d2_b[11:8]);
          q2_exp.push_back(4'(xa & xb));
        end
        hold = d2_valid_o && !(rdy && en);
        frz  = !en;
        pv   = d2_valid_o;
        pq   = d2_q;
        cyc++;
      end
      check("d2_ops_done", done2, 1000);
      @(negedge clk);
      d2_valid_i = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
